// File: rtl/l1d_port_arbiter.sv
// Issue-side arbiter for the dual-port L1D: forwards a two-lane load/store bundle
// per cycle and serialises same-line bundles with a write (lane A first, then lane B).
module l1d_port_arbiter #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned OPC_W   = 7,
  parameter int unsigned WBA_W   = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,

  input  logic              loadStoreA_i,
  input  logic              isWbA_i,
  input  logic [WBA_W-1:0]  wbAddressA_i,
  input  logic [OPC_W-1:0]  opCodeA_i,
  input  logic [DATA_W-1:0] pOperandA_i,
  input  logic [DATA_W-1:0] sOperandA_i,

  input  logic              loadStoreB_i,
  input  logic              isWbB_i,
  input  logic [WBA_W-1:0]  wbAddressB_i,
  input  logic [OPC_W-1:0]  opCodeB_i,
  input  logic [DATA_W-1:0] pOperandB_i,
  input  logic [DATA_W-1:0] sOperandB_i,

  output logic              loadStoreA_o,
  output logic              isWbA_o,
  output logic [WBA_W-1:0]  wbAddressA_o,
  output logic [OPC_W-1:0]  opCodeA_o,
  output logic [DATA_W-1:0] pOperandA_o,
  output logic [DATA_W-1:0] sOperandA_o,

  output logic              loadStoreB_o,
  output logic              isWbB_o,
  output logic [WBA_W-1:0]  wbAddressB_o,
  output logic [OPC_W-1:0]  opCodeB_o,
  output logic [DATA_W-1:0] pOperandB_o,
  output logic [DATA_W-1:0] sOperandB_o,

  output logic              conflict_o,
  output logic [CNT_W-1:0]  conflictCount_o
);

  localparam logic [OPC_W-1:0] OPC_LOAD  = OPC_W'(11);
  localparam logic [OPC_W-1:0] OPC_STORE = OPC_W'(12);

  typedef struct packed {
    logic              ls;
    logic              is_wb;
    logic [WBA_W-1:0]  wb_addr;
    logic [OPC_W-1:0]  opc;
    logic [DATA_W-1:0] p_op;
    logic [DATA_W-1:0] s_op;
  } lane_t;

  typedef enum logic {ST_PASS, ST_HOLD} state_t;

  state_t           state_q, state_d;
  lane_t            lane_a_q, lane_a_d;
  lane_t            lane_b_q, lane_b_d;
  lane_t            hold_q, hold_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] count_q, count_d;

  lane_t in_a_c, in_b_c;
  logic  mem_a_c, mem_b_c, conflict_c;

  // A disabled lane is presented to the cache with enable and opcode cleared.
  function automatic lane_t gate_lane(input lane_t l);
    lane_t r;
    r = l;
    if (!l.ls) begin
      r.opc = '0;
    end
    return r;
  endfunction

  always_comb begin
    in_a_c = '{ls: loadStoreA_i, is_wb: isWbA_i, wb_addr: wbAddressA_i,
               opc: opCodeA_i, p_op: pOperandA_i, s_op: sOperandA_i};
    in_b_c = '{ls: loadStoreB_i, is_wb: isWbB_i, wb_addr: wbAddressB_i,
               opc: opCodeB_i, p_op: pOperandB_i, s_op: sOperandB_i};
  end

  // Same cache line with at least one store; read-read is safe on a dual-port array.
  always_comb begin
    mem_a_c    = (opCodeA_i == OPC_LOAD) || (opCodeA_i == OPC_STORE);
    mem_b_c    = (opCodeB_i == OPC_LOAD) || (opCodeB_i == OPC_STORE);
    conflict_c = loadStoreA_i && loadStoreB_i && mem_a_c && mem_b_c &&
                 ((opCodeA_i == OPC_STORE) || (opCodeB_i == OPC_STORE)) &&
                 (sOperandA_i[INDEX_W-1:0] == sOperandB_i[INDEX_W-1:0]);
  end

  always_comb begin
    state_d      = state_q;
    lane_a_d     = lane_a_q;
    lane_a_d.ls  = 1'b0;
    lane_a_d.opc = '0;
    lane_b_d     = lane_b_q;
    lane_b_d.ls  = 1'b0;
    lane_b_d.opc = '0;
    hold_d       = hold_q;
    conflict_d   = 1'b0;
    count_d      = count_q;

    if (flush_i) begin
      state_d = ST_PASS;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_PASS: begin
          if (valid_i) begin
            lane_a_d = gate_lane(in_a_c);
            if (conflict_c) begin
              hold_d     = gate_lane(in_b_c);
              conflict_d = 1'b1;
              state_d    = ST_HOLD;
              if (count_q != '1) begin
                count_d = count_q + CNT_W'(1);
              end
            end else begin
              lane_b_d = gate_lane(in_b_c);
            end
          end
        end
        ST_HOLD: begin
          lane_b_d = hold_q;
          state_d  = ST_PASS;
        end
        default: state_d = ST_PASS;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_PASS;
      lane_a_q   <= '0;
      lane_b_q   <= '0;
      hold_q     <= '0;
      conflict_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      lane_a_q   <= lane_a_d;
      lane_b_q   <= lane_b_d;
      hold_q     <= hold_d;
      conflict_q <= conflict_d;
      count_q    <= count_d;
    end
  end

  assign ready_o         = (state_q == ST_PASS);
  assign conflict_o      = conflict_q;
  assign conflictCount_o = count_q;

  assign loadStoreA_o = lane_a_q.ls;
  assign isWbA_o      = lane_a_q.is_wb;
  assign wbAddressA_o = lane_a_q.wb_addr;
  assign opCodeA_o    = lane_a_q.opc;
  assign pOperandA_o  = lane_a_q.p_op;
  assign sOperandA_o  = lane_a_q.s_op;

  assign loadStoreB_o = lane_b_q.ls;
  assign isWbB_o      = lane_b_q.is_wb;
  assign wbAddressB_o = lane_b_q.wb_addr;
  assign opCodeB_o    = lane_b_q.opc;
  assign pOperandB_o  = lane_b_q.p_op;
  assign sOperandB_o  = lane_b_q.s_op;

endmodule

// File: doc/l1d_port_arbiter.md
Name: l1d_port_arbiter

Overview:
Issue-side controller in front of the dual-port L1 data cache. Takes one two-lane load/store bundle per cycle from the execute stage and forwards it to cache ports A and B. When both lanes touch the same cache line and at least one lane writes, it splits the bundle across two cycles: lane A goes first, lane B follows. This keeps results deterministic, since lane A is always program-order older than lane B. It also counts the conflicts it resolves, for performance monitoring.

Parameters:
DATA_W, 16, operand/data width
INDEX_W, 8, low sOperand bits used as cache line index (256 lines)
OPC_W, 7, opcode width
WBA_W, 5, register writeback address width
CNT_W, 16, conflict counter width

Ports:
clock_i  in  1  clock, all logic on posedge
reset_i  in  1  synchronous active-high reset
flush_i  in  1  drop held lane-B op and any accept this cycle
valid_i  in  1  bundle valid
ready_o  out  1  arbiter can accept a bundle (bundle accepted when valid_i && ready_o)
loadStoreA_i / loadStoreB_i  in  1  lane enable
isWbA_i / isWbB_i  in  1  lane writes back a register
wbAddressA_i / wbAddressB_i  in  WBA_W  writeback register
opCodeA_i / opCodeB_i  in  OPC_W  0 nop, 10 immediate-to-reg, 11 load, 12 store
pOperandA_i / pOperandB_i  in  DATA_W  store data
sOperandA_i / sOperandB_i  in  DATA_W  address or immediate
loadStoreA_o / loadStoreB_o  out  1  cache port enable
isWbA_o / isWbB_o, wbAddressA_o / wbAddressB_o, opCodeA_o / opCodeB_o, pOperandA_o / pOperandB_o, sOperandA_o / sOperandB_o  out  as inputs  registered copies to cache ports
conflict_o  out  1  one-cycle pulse, registered, coincident with the lane-A-only issue cycle
conflictCount_o  out  CNT_W  saturating count of resolved conflicts

Behaviour:
- One clock (clock_i); reset_i is synchronous and active-high.
- Reset state:
  - state=PASS, ready_o=1.
  - All *_o lane outputs 0, including loadStore*_o=0 and opCode*_o=0.
  - conflict_o=0, conflictCount_o=0.
  - The hold register is cleared.
- Conflict definition (combinational on inputs): loadStoreA_i && loadStoreB_i && both opcodes in {11,12} && at least one opcode == 12 && sOperandA_i[INDEX_W-1:0] == sOperandB_i[INDEX_W-1:0].
  - Read-read to the same line is not a conflict.
  - Opcodes 0, 10 and undefined opcodes never conflict.
- ready_o = (state == PASS). It is combinational from state only, with no path from valid_i.
- Latency is 1 cycle from accept to the cache port outputs. All outputs are registered.
- PASS, accept, no conflict:
  - Both lanes are copied to outputs next cycle.
  - A disabled lane outputs loadStore=0, opCode=0.
  - state stays PASS.
- PASS, accept, conflict:
  - Next cycle: lane A output as normal, lane B output loadStoreB_o=0 / opCodeB_o=0, conflict_o=1.
  - Lane B fields are captured into the hold register.
  - state -> HOLD. conflictCount_o increments, saturating at all-ones.
- PASS, no accept: both lane enables and opcodes go to 0 next cycle. Other output fields are don't-care but held stable.
- HOLD:
  - ready_o=0.
  - Next cycle: lane B = hold register, lane A disabled, conflict_o=0. state -> PASS.
  - valid_i is ignored.
- flush_i has priority over everything except reset_i:
  - In HOLD: the held op is discarded, lane outputs are disabled next cycle, state -> PASS.
  - In PASS: the bundle is not accepted and lane outputs are disabled next cycle.
  - conflictCount_o is not decremented.
- Reset mid-HOLD: the held op is lost and all reset values apply next cycle.
- Throughput:
  - Non-conflicting: 1 bundle/cycle.
  - Conflicting: 1 bundle per 2 cycles, with a 1-cycle ready_o gap.
- Pass-through fields are not modified. The arbiter does not alter isWb or wbAddress and never reorders lane A after lane B.

Test Plan:
- Reset: hold reset_i=1 for 2 cycles with valid_i=1 -> ready_o=1; loadStoreA_o=loadStoreB_o=0; conflictCount_o=0; conflict_o=0.
- No conflict: A=load(11) addr 0x0010, B=store(12) addr 0x0011 data 0xBEEF -> next cycle both lanes out with identical fields; ready_o stays 1; count stays 0.
- Store/load conflict: A=store addr 0x0105 data 0x1234, B=load addr 0x0005 (same index 0x05) -> cycle+1: A only, conflict_o=1, ready_o=0; cycle+2: B only with sOperandB_o=0x0005; ready_o=1; count=1.
- Read-read same address: A=11 and B=11, both addr 0x0042 -> issued together; conflict_o=0.
- Flush in HOLD: create a conflict, assert flush_i during the HOLD cycle -> next cycle both lanes disabled; B never issued; state PASS; count=1.
- Saturation: preload the counter via 65535 back-to-back conflicts (or force CNT_W=4 and issue 16 conflicts) -> counter holds all-ones, no wrap.
